// File: rtl/lsu_ecc_wb_ctl_pkg.sv
// rtl/lsu_ecc_wb_ctl_pkg.sv - shared types and constants for the DCCM ECC writeback controller
package lsu_ecc_wb_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } ecc_wb_state_t;

  localparam int ECC_WB_STARVE_MAX = 4;

endpackage

// File: rtl/rvecc_encode.sv
// rvecc_encode.sv - SECDED encoder: 32 data bits to 6 Hamming bits plus overall parity
module rvecc_encode (
  input  logic [31:0] din,
  output logic [6:0]  ecc_out
);

  logic [6:0] e;
  logic [5:0] k;

  // Data bits occupy the non-power-of-two codeword positions 3..38 in order.
  always_comb begin
    e = '0;
    k = '0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int i = 0; i < 6; i++) begin
          if (p[i]) e[i] = e[i] ^ din[k[4:0]];
        end
        k = k + 6'd1;
      end
    end
    e[6] = ^{din, e[5:0]};
  end

  assign ecc_out = e;

endmodule

// File: rtl/lsu_ecc_wb_ctl.sv
// rtl/lsu_ecc_wb_ctl.sv - DCCM single-bit-error correction writeback controller
// Shares the DCCM write port between store-buffer drains and corrected-word writebacks.
module lsu_ecc_wb_ctl
  import lsu_ecc_wb_ctl_pkg::*;
#(
  parameter int DCCM_BITS       = 16,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int DCCM_ECC_WIDTH  = 7,
  parameter int STARVE_MAX      = ECC_WB_STARVE_MAX
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       dec_tlu_core_ecc_disable,
  input  logic                       ecc_err_valid_dc4,
  input  logic                       ecc_err_lo_dc4,
  input  logic                       ecc_err_hi_dc4,
  input  logic [DCCM_BITS-1:0]       ecc_addr_lo_dc4,
  input  logic [DCCM_BITS-1:0]       ecc_addr_hi_dc4,
  input  logic [DCCM_DATA_WIDTH-1:0] ecc_data_lo_dc4,
  input  logic [DCCM_DATA_WIDTH-1:0] ecc_data_hi_dc4,
  input  logic                       stbuf_wr_req,
  input  logic [DCCM_BITS-1:0]       stbuf_wr_addr,
  input  logic [DCCM_DATA_WIDTH-1:0] stbuf_wr_data,
  output logic                       stbuf_wr_ack,
  output logic                       dccm_wren,
  output logic [DCCM_BITS-1:0]       dccm_wr_addr,
  output logic [DCCM_DATA_WIDTH-1:0] dccm_wr_data,
  output logic [DCCM_ECC_WIDTH-1:0]  dccm_wr_ecc,
  output logic                       ecc_wb_busy,
  output logic                       ecc_err_dropped
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  ecc_wb_state_t              state_q, state_d;
  logic [SW-1:0]              starve_q, starve_d;
  logic                       pend_lo_q, pend_lo_d;
  logic                       pend_hi_q, pend_hi_d;
  logic                       dropped_q, dropped_d;
  logic [DCCM_BITS-1:0]       addr_lo_q, addr_lo_d;
  logic [DCCM_BITS-1:0]       addr_hi_q, addr_hi_d;
  logic [DCCM_DATA_WIDTH-1:0] data_lo_q, data_lo_d;
  logic [DCCM_DATA_WIDTH-1:0] data_hi_q, data_hi_d;

  logic in_wr, cur_pend, cur_left, grant, corr_wr, hit_lo, hit_hi, err_any;
  logic [DCCM_BITS-1:0]       wr_addr;
  logic [DCCM_DATA_WIDTH-1:0] wr_data;

  // Port arbitration; outputs are forced quiet while reset is asserted.
  always_comb begin
    in_wr    = (state_q != IDLE);
    err_any  = ecc_err_valid_dc4 & (ecc_err_lo_dc4 | ecc_err_hi_dc4) & ~dec_tlu_core_ecc_disable;
    cur_pend = (state_q == WR_LO) ? pend_lo_q : pend_hi_q;
    grant    = rst_l & stbuf_wr_req & (~in_wr | (starve_q < SW'(STARVE_MAX)));
    corr_wr  = rst_l & in_wr & ~grant & cur_pend;
    hit_lo   = grant & pend_lo_q &
               (stbuf_wr_addr[DCCM_BITS-1:2] == addr_lo_q[DCCM_BITS-1:2]);
    hit_hi   = grant & pend_hi_q &
               (stbuf_wr_addr[DCCM_BITS-1:2] == addr_hi_q[DCCM_BITS-1:2]);
    wr_addr  = '0;
    wr_data  = '0;
    if (grant) begin
      wr_addr = stbuf_wr_addr;
      wr_data = stbuf_wr_data;
    end else if (corr_wr) begin
      wr_addr = (state_q == WR_LO) ? addr_lo_q : addr_hi_q;
      wr_data = (state_q == WR_LO) ? data_lo_q : data_hi_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    pend_lo_d = pend_lo_q;
    pend_hi_d = pend_hi_q;
    addr_lo_d = addr_lo_q;
    addr_hi_d = addr_hi_q;
    data_lo_d = data_lo_q;
    data_hi_d = data_hi_q;
    dropped_d = err_any & in_wr;
    cur_left  = 1'b0;
    case (state_q)
      IDLE: begin
        starve_d = '0;
        if (err_any) begin
          addr_lo_d = ecc_addr_lo_dc4;
          addr_hi_d = ecc_addr_hi_dc4;
          data_lo_d = ecc_data_lo_dc4;
          data_hi_d = ecc_data_hi_dc4;
          pend_lo_d = ecc_err_lo_dc4;
          pend_hi_d = ecc_err_hi_dc4;
          state_d   = ecc_err_lo_dc4 ? WR_LO : WR_HI;
        end
      end
      default: begin
        // A newer store to a pending word supersedes the correction for it.
        pend_lo_d = pend_lo_q & ~hit_lo;
        pend_hi_d = pend_hi_q & ~hit_hi;
        if (grant) begin
          starve_d = starve_q + SW'(1);
        end else if (state_q == WR_LO) begin
          pend_lo_d = 1'b0;
        end else begin
          pend_hi_d = 1'b0;
        end
        cur_left = (state_q == WR_LO) ? pend_lo_d : pend_hi_d;
        if (!cur_left) begin
          starve_d = '0;
          state_d  = ((state_q == WR_LO) && pend_hi_d) ? WR_HI : IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      pend_lo_q <= 1'b0;
      pend_hi_q <= 1'b0;
      dropped_q <= 1'b0;
      addr_lo_q <= '0;
      addr_hi_q <= '0;
      data_lo_q <= '0;
      data_hi_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      pend_lo_q <= pend_lo_d;
      pend_hi_q <= pend_hi_d;
      dropped_q <= dropped_d;
      addr_lo_q <= addr_lo_d;
      addr_hi_q <= addr_hi_d;
      data_lo_q <= data_lo_d;
      data_hi_q <= data_hi_d;
    end
  end

  rvecc_encode u_ecc_enc (
    .din     (wr_data),
    .ecc_out (dccm_wr_ecc)
  );

  assign stbuf_wr_ack    = grant;
  assign dccm_wren       = grant | corr_wr;
  assign dccm_wr_addr    = wr_addr;
  assign dccm_wr_data    = wr_data;
  assign ecc_wb_busy     = in_wr;
  assign ecc_err_dropped = dropped_q;

endmodule
